nibbler_branch_sequencer: RTL and testbench

- Fetch/execute sequencer for the Nibbler core, and the consumer of the flags register's 2-bit output.
- Owns the 12-bit program counter, fetches instruction bytes from program ROM, and evaluates the stored active-low carry/zero flags to resolve conditional jumps.
- Emits a one-cycle execute strobe that enables the ALU and flags-register loads for non-jump instructions.

---
 rtl/nibbler_pkg.sv | 24 ++
 rtl/nibbler_branch_cond.sv | 23 ++
 rtl/nibbler_branch_sequencer.sv | 91 +++++++++
 tb/tb_nibbler_branch_sequencer.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/nibbler_pkg.sv
// Shared definitions for the Nibbler core: opcodes, sequencer
// states and flag bit positions.
package nibbler_pkg;

  localparam logic [3:0] OP_JC  = 4'hA;
  localparam logic [3:0] OP_JNC = 4'hB;
  localparam logic [3:0] OP_JZ  = 4'hC;
  localparam logic [3:0] OP_JNZ = 4'hD;
  localparam logic [3:0] OP_JMP = 4'hE;

  localparam int FLAG_NC = 1;
  localparam int FLAG_NZ = 0;

  typedef enum logic [1:0] {
    FETCH,
    OPERAND,
    EXEC
  } seq_state_t;

  function automatic logic is_jump(logic [3:0] op);
    return (op >= OP_JC) && (op <= OP_JMP);
  endfunction

endpackage

// File: rtl/nibbler_branch_cond.sv
// Jump condition evaluator: opcode plus active-low flags
// gives a taken decision; non-jump opcodes are never taken.
module nibbler_branch_cond
  import nibbler_pkg::*;
(
  input  logic [3:0] op,
  input  logic [1:0] flags_n,
  output logic       taken
);

  always_comb begin
    taken = 1'b0;
    unique case (1'b1)
      op == OP_JC:  taken = ~flags_n[FLAG_NC];
      op == OP_JNC: taken =  flags_n[FLAG_NC];
      op == OP_JZ:  taken = ~flags_n[FLAG_NZ];
      op == OP_JNZ: taken =  flags_n[FLAG_NZ];
      op == OP_JMP: taken = 1'b1;
      default:      taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/nibbler_branch_sequencer.sv
// Fetch/operand/execute sequencer: owns the PC, latches the
// instruction byte and resolves conditional jumps.
module nibbler_branch_sequencer
  import nibbler_pkg::*;
#(
  parameter int              PC_W     = 12,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            hold,
  input  logic [7:0]      rom_data,
  input  logic [1:0]      flags_n,
  output logic [PC_W-1:0] rom_addr,
  output logic [7:0]      ir,
  output logic            exec_strobe,
  output logic            branch_taken,
  output logic            is_fetch
);

  seq_state_t      state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [7:0]      ir_q, ir_d;
  logic [7:0]      lo_q, lo_d;
  logic            taken;
  logic [PC_W-1:0] target;
  logic [PC_W-1:0] pc_inc;

  nibbler_branch_cond u_cond (
    .op      (ir_q[7:4]),
    .flags_n (flags_n),
    .taken   (taken)
  );

  assign target = PC_W'({ir_q[3:0], lo_q});
  assign pc_inc = pc_q + PC_W'(1);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= FETCH;
      pc_q    <= RESET_PC;
      ir_q    <= 8'h00;
      lo_q    <= 8'h00;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      lo_q    <= lo_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    ir_d         = ir_q;
    lo_d         = lo_q;
    exec_strobe  = 1'b0;
    branch_taken = 1'b0;
    if (!hold) begin
      unique case (state_q)
        FETCH: begin
          ir_d    = rom_data;
          pc_d    = pc_inc;
          state_d = is_jump(rom_data[7:4]) ? OPERAND : EXEC;
        end
        OPERAND: begin
          lo_d    = rom_data;
          pc_d    = pc_inc;
          state_d = EXEC;
        end
        EXEC: begin
          state_d = FETCH;
          if (is_jump(ir_q[7:4])) begin
            if (taken) begin
              pc_d         = target;
              branch_taken = 1'b1;
            end
          end else begin
            exec_strobe = 1'b1;
          end
        end
        default: state_d = FETCH;
      endcase
    end
  end

  assign rom_addr = pc_q;
  assign ir       = ir_q;
  assign is_fetch = (state_q == FETCH);

endmodule

// File: tb/tb_nibbler_branch_sequencer.sv
// Directed and randomized checks of the sequencer against an
// instruction-level reference model driving a behavioural ROM.
module tb_nibbler_branch_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        hold = 1'b0;
  logic [7:0]  rom_data;
  logic [1:0]  flags_n = 2'b11;
  logic [11:0] rom_addr;
  logic [7:0]  ir;
  logic        exec_strobe;
  logic        branch_taken;
  logic        is_fetch;

  logic [7:0] rom [4096];
  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [11:0] addr;
    bit          fetch;
    bit          ex;
    bit          jx;
    logic [7:0]  op;
    logic [11:0] nxt;
    logic [11:0] tgt;
  } cyc_t;

  cyc_t        q[$];
  cyc_t        cur;
  logic [11:0] m_pc;

  nibbler_branch_sequencer #(
    .PC_W     (12),
    .RESET_PC (12'h000)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .hold         (hold),
    .rom_data     (rom_data),
    .flags_n      (flags_n),
    .rom_addr     (rom_addr),
    .ir           (ir),
    .exec_strobe  (exec_strobe),
    .branch_taken (branch_taken),
    .is_fetch     (is_fetch)
  );

  assign rom_data = rom[rom_addr];

  always #5 clk = ~clk;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic expect_o(string t, logic [11:0] a, bit s, bit b, bit f);
    #1;
    chk({t, ".addr"}, 32'(rom_addr), 32'(a));
    chk({t, ".exec"}, 32'(exec_strobe), 32'(s));
    chk({t, ".br"}, 32'(branch_taken), 32'(b));
    chk({t, ".fetch"}, 32'(is_fetch), 32'(f));
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    #2;
    reset = 1'b1;
  endtask

  // Condition rules stated directly from carry/zero semantics
  function automatic bit ref_taken(logic [3:0] op, logic [1:0] f);
    bit c, z;
    c = (f[1] == 1'b0);
    z = (f[0] == 1'b0);
    case (op)
      4'hA: return c;
      4'hB: return !c;
      4'hC: return z;
      4'hD: return !z;
      4'hE: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  task automatic build_instr();
    cyc_t r;
    logic [7:0] b0;
    b0 = rom[m_pc];
    r = '{addr: m_pc, fetch: 1, ex: 0, jx: 0, op: b0,
          nxt: 12'h0, tgt: 12'h0};
    q.push_back(r);
    if (b0[7:4] >= 4'hA && b0[7:4] <= 4'hE) begin
      r.fetch = 0;
      r.addr = m_pc + 12'd1;
      q.push_back(r);
      r.addr = m_pc + 12'd2;
      r.jx = 1;
      r.nxt = m_pc + 12'd2;
      r.tgt = {b0[3:0], rom[m_pc + 12'd1]};
      q.push_back(r);
    end else begin
      r.fetch = 0;
      r.ex = 1;
      r.addr = m_pc + 12'd1;
      r.nxt = m_pc + 12'd1;
      q.push_back(r);
    end
  endtask

  initial begin
    bit exp_b, exp_s;
    for (int i = 0; i < 4096; i++) rom[i] = 8'h00;

    // reset mid-OPERAND
    rom[0] = 8'hA3; rom[1] = 8'h45;
    do_reset();
    expect_o("rst.c1", 12'h000, 0, 0, 1);
    cyc();
    expect_o("rst.c2", 12'h001, 0, 0, 0);
    #3 reset = 1'b0;
    expect_o("rst.async", 12'h000, 0, 0, 1);
    chk("rst.ir", 32'(ir), 32'h0);
    reset = 1'b1;

    // linear run
    rom[0] = 8'h12; rom[1] = 8'h34;
    do_reset();
    expect_o("lin.c1", 12'h000, 0, 0, 1);
    cyc();
    expect_o("lin.c2", 12'h001, 1, 0, 0);
    chk("lin.ir1", 32'(ir), 32'h12);
    cyc();
    expect_o("lin.c3", 12'h001, 0, 0, 1);
    cyc();
    expect_o("lin.c4", 12'h002, 1, 0, 0);
    chk("lin.ir2", 32'(ir), 32'h34);

    // JC taken / not taken
    rom[0] = 8'hA3; rom[1] = 8'h45;
    for (int k = 0; k < 2; k++) begin
      flags_n = (k == 0) ? 2'b01 : 2'b11;
      do_reset();
      expect_o("jc.c1", 12'h000, 0, 0, 1);
      cyc();
      expect_o("jc.c2", 12'h001, 0, 0, 0);
      cyc();
      expect_o("jc.c3", 12'h002, 0, k == 0, 0);
      cyc();
      expect_o("jc.c4", (k == 0) ? 12'h345 : 12'h002, 0, 0, 1);
    end

    // JZ / JNZ with Z set
    rom[1] = 8'hF0;
    for (int k = 0; k < 2; k++) begin
      rom[0] = (k == 0) ? 8'hC0 : 8'hD0;
      flags_n = 2'b10;
      do_reset();
      cyc();
      cyc();
      expect_o("jz.c3", 12'h002, 0, k == 0, 0);
      cyc();
      expect_o("jz.c4", (k == 0) ? 12'h0F0 : 12'h002, 0, 0, 1);
    end

    // flags only matter in EXEC
    rom[0] = 8'hC0;
    for (int k = 0; k < 2; k++) begin
      flags_n = (k == 0) ? 2'b11 : 2'b10;
      do_reset();
      cyc();
      flags_n = (k == 0) ? 2'b11 : 2'b10;
      cyc();
      flags_n = (k == 0) ? 2'b10 : 2'b11;
      expect_o("late.c3", 12'h002, 0, k == 0, 0);
      cyc();
      expect_o("late.c4", (k == 0) ? 12'h0F0 : 12'h002, 0, 0, 1);
    end

    // PC wrap through FFF
    rom[0] = 8'hEF; rom[1] = 8'hFF; rom[12'hFFF] = 8'hE1;
    flags_n = 2'b11;
    do_reset();
    cyc();
    cyc();
    expect_o("wrap.c3", 12'h002, 0, 1, 0);
    cyc();
    rom[0] = 8'h00;
    expect_o("wrap.c4", 12'hFFF, 0, 0, 1);
    cyc();
    expect_o("wrap.c5", 12'h000, 0, 0, 0);
    cyc();
    expect_o("wrap.c6", 12'h001, 0, 1, 0);
    chk("wrap.ir", 32'(ir), 32'hE1);
    cyc();
    expect_o("wrap.c7", 12'h100, 0, 0, 1);

    // hold in EXEC of a non-jump
    rom[0] = 8'h12; rom[1] = 8'h34;
    do_reset();
    expect_o("hold.c1", 12'h000, 0, 0, 1);
    for (int k = 0; k < 3; k++) begin
      cyc();
      hold = 1'b1;
      expect_o("hold.h", 12'h001, 0, 0, 0);
    end
    cyc();
    hold = 1'b0;
    expect_o("hold.rel", 12'h001, 1, 0, 0);
    cyc();
    expect_o("hold.after", 12'h001, 0, 0, 1);

    // randomized run against the instruction-level model
    for (int i = 0; i < 4096; i++) begin
      rom[i] = 8'($urandom);
      if ($urandom_range(0, 1) == 1)
        rom[i][7:4] = 4'($urandom_range(10, 14));
    end
    q.delete();
    m_pc = 12'h000;
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      hold = ($urandom_range(0, 4) == 0);
      flags_n = 2'($urandom);
      if (q.size() == 0) build_instr();
      cur = q[0];
      exp_s = !hold && cur.ex;
      exp_b = !hold && cur.jx && ref_taken(cur.op[7:4], flags_n);
      expect_o("rnd", cur.addr, exp_s, exp_b, cur.fetch);
      if (!cur.fetch) chk("rnd.ir", 32'(ir), 32'(cur.op));
      if (!hold) begin
        if (cur.ex) m_pc = cur.nxt;
        if (cur.jx) m_pc = exp_b ? cur.tgt : cur.nxt;
        void'(q.pop_front());
      end
      cyc();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
